// File: rtl/coffee_vend_pkg.sv
// Shared types and constants for the coffee dispense back end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package coffee_vend_pkg;

  localparam int         AMT_W     = 6;      // change amount, rupees
  localparam int         STOCK_W   = 3;      // cup stock counter
  localparam int         COINS_W   = 4;      // up to floor(63/5) = 12 coins
  localparam int         COIN_VAL  = 5;      // rupees per change coin
  localparam logic [1:0] VEND_CODE = 2'b01;  // coffee code meaning "vend"

  typedef enum logic [2:0] {
    S_IDLE,
    S_CUP,
    S_BREW,
    S_POUR,
    S_CHANGE,
    S_DONE
  } state_t;

  // Whole coins owed; the sub-coin remainder is simply not paid out.
  function automatic logic [COINS_W-1:0] coin_count(input logic [AMT_W-1:0] amt);
    return COINS_W'(amt / AMT_W'(COIN_VAL));
  endfunction

endpackage

// File: rtl/change_coin_gen.sv
// Change coin ejector: one change_coin pulse per slot of COIN_GAP cycles.
// Latency: first coin is driven the cycle after start; fin marks the last cycle.
// Backpressure: none; start must only be pulsed while idle.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   start         one-cycle pulse, loads coins
//   coins[3:0]    number of coins to eject (0 gives a single idle cycle)
//   change_coin   registered coin pulse
//   fin           high during the final cycle of the sequence
module change_coin_gen
  import coffee_vend_pkg::*;
#(
  parameter int COIN_GAP = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COINS_W-1:0] coins,
  output logic               change_coin,
  output logic               fin
);

  localparam int GAP_W = $clog2(COIN_GAP);

  logic               active;
  logic [COINS_W-1:0] rem;  // coins still to eject after the current slot
  logic [GAP_W-1:0]   gap;  // cycles left in the current slot after this one

  // Sequence ends once the last slot has run out; a zero-coin request
  // therefore finishes in its first cycle.
  assign fin = active && (rem == '0) && (gap == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      active      <= 1'b0;
      rem         <= '0;
      gap         <= '0;
      change_coin <= 1'b0;
    end else if (start) begin
      active <= 1'b1;
      if (coins != '0) begin
        change_coin <= 1'b1;
        rem         <= coins - COINS_W'(1);
        gap         <= GAP_W'(COIN_GAP - 1);
      end else begin
        change_coin <= 1'b0;
        rem         <= '0;
        gap         <= '0;
      end
    end else if (active) begin
      if (gap != '0) begin
        change_coin <= 1'b0;
        gap         <= gap - GAP_W'(1);
      end else if (rem != '0) begin
        change_coin <= 1'b1;
        rem         <= rem - COINS_W'(1);
        gap         <= GAP_W'(COIN_GAP - 1);
      end else begin
        change_coin <= 1'b0;
        active      <= 1'b0;
      end
    end else begin
      change_coin <= 1'b0;
    end
  end

endmodule

// File: rtl/coffee_dispense_ctrl.sv
// Dispense sequencer: cup, brew, pour, optional change, with cup stock and a one-deep request queue.
// Latency: CUP_CYC+BREW_CYC+POUR_CYC(+max(1,coins*COIN_GAP) with change)+1 cycles from acceptance to done.
// Backpressure: none; one extra request is queued while busy, further ones pulse req_drop.
//
// Optional feature: define CHANGE_RETURN_EN to add the CHANGE state and coin ejector;
// without it POUR goes straight to DONE, change_coin is 0 and balance is ignored.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   coffee[1:0], balance[5:0]   vend request (2'b01, edge detected) and change owed
//   cup_drop, brew_on, pour_on  registered actuators, never overlapping
//   change_coin                 one pulse per Rs5 coin
//   busy, done                  not idle / one-cycle completion pulse
//   reject, req_drop            refused for empty stock / lost to a full queue
//   stock[2:0], out_of_stock    cups remaining / stock == 0
module coffee_dispense_ctrl
  import coffee_vend_pkg::*;
#(
  parameter int CUP_CYC  = 4,
  parameter int BREW_CYC = 16,
  parameter int POUR_CYC = 8,
  parameter int COIN_GAP = 2,
  parameter int STOCK    = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         coffee,
  input  logic [AMT_W-1:0]   balance,
  output logic               cup_drop,
  output logic               brew_on,
  output logic               pour_on,
  output logic               change_coin,
  output logic               busy,
  output logic               done,
  output logic               reject,
  output logic               req_drop,
  output logic [STOCK_W-1:0] stock,
  output logic               out_of_stock
);

  localparam int MAX_CYC = (CUP_CYC > BREW_CYC) ?
                           ((CUP_CYC > POUR_CYC) ? CUP_CYC : POUR_CYC) :
                           ((BREW_CYC > POUR_CYC) ? BREW_CYC : POUR_CYC);
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;       // shared phase timer, counts down to 0
  logic [1:0]       coffee_q;
  logic             pend;
  logic             req;

  // A held vend level produces one request only.
  assign req          = (coffee == VEND_CODE) && (coffee_q != VEND_CODE);
  assign busy         = (state != S_IDLE);
  assign out_of_stock = (stock == '0);

`ifdef CHANGE_RETURN_EN
  logic [AMT_W-1:0] bal_q;
  logic [AMT_W-1:0] pend_bal;
  logic             coin_start;
  logic             coin_fin;

  // Load the ejector on the last POUR cycle so the first coin coincides
  // with the first CHANGE cycle.
  assign coin_start = (state == S_POUR) && (cnt == '0);

  change_coin_gen #(
    .COIN_GAP(COIN_GAP)
  ) u_change_coin_gen (
    .clk        (clk),
    .rst        (rst),
    .start      (coin_start),
    .coins      (coin_count(bal_q)),
    .change_coin(change_coin),
    .fin        (coin_fin)
  );
`else
  logic unused_balance;
  assign unused_balance = ^balance;
  assign change_coin    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      coffee_q <= 2'b00;
      pend     <= 1'b0;
      stock    <= STOCK_W'(STOCK);
      cup_drop <= 1'b0;
      brew_on  <= 1'b0;
      pour_on  <= 1'b0;
      done     <= 1'b0;
      reject   <= 1'b0;
      req_drop <= 1'b0;
`ifdef CHANGE_RETURN_EN
      bal_q    <= '0;
      pend_bal <= '0;
`endif
    end else begin
      coffee_q <= coffee;
      done     <= 1'b0;
      reject   <= 1'b0;
      req_drop <= 1'b0;

      // Requests while busy (DONE included) go to the one-deep queue.
      if (req && (state != S_IDLE)) begin
        if (!pend) begin
          pend <= 1'b1;
`ifdef CHANGE_RETURN_EN
          pend_bal <= balance;
`endif
        end else begin
          req_drop <= 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (req) begin
            if (stock != '0) begin
              stock    <= stock - STOCK_W'(1);
              state    <= S_CUP;
              cup_drop <= 1'b1;
              cnt      <= CNT_W'(CUP_CYC - 1);
`ifdef CHANGE_RETURN_EN
              bal_q    <= balance;
`endif
            end else begin
              reject <= 1'b1;
            end
          end
        end
        S_CUP: begin
          if (cnt == '0) begin
            cup_drop <= 1'b0;
            brew_on  <= 1'b1;
            cnt      <= CNT_W'(BREW_CYC - 1);
            state    <= S_BREW;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_BREW: begin
          if (cnt == '0) begin
            brew_on <= 1'b0;
            pour_on <= 1'b1;
            cnt     <= CNT_W'(POUR_CYC - 1);
            state   <= S_POUR;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_POUR: begin
          if (cnt == '0) begin
            pour_on <= 1'b0;
`ifdef CHANGE_RETURN_EN
            state   <= S_CHANGE;
`else
            state   <= S_DONE;
            done    <= 1'b1;
`endif
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
`ifdef CHANGE_RETURN_EN
        S_CHANGE: begin
          if (coin_fin) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
`endif
        S_DONE: begin
          // A queued request starts straight away, with no IDLE gap.
          if (pend && (stock != '0)) begin
            pend     <= 1'b0;
            stock    <= stock - STOCK_W'(1);
            state    <= S_CUP;
            cup_drop <= 1'b1;
            cnt      <= CNT_W'(CUP_CYC - 1);
`ifdef CHANGE_RETURN_EN
            bal_q    <= pend_bal;
`endif
          end else if (pend) begin
            pend   <= 1'b0;
            reject <= 1'b1;
            state  <= S_IDLE;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coffee_dispense_ctrl.sv
// Directed bench for coffee_dispense_ctrl with a scoreboard of expected dispenses.
module tb_coffee_dispense_ctrl;

  localparam int CUP  = 4;
  localparam int BREW = 16;
  localparam int POUR = 8;
  localparam int GAP  = 2;
  localparam int STK  = 7;
`ifdef CHANGE_RETURN_EN
  localparam bit CHG = 1'b1;
`else
  localparam bit CHG = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [1:0] coffee;
  logic [5:0] balance;
  logic       cup_drop, brew_on, pour_on, change_coin;
  logic       busy, done, reject, req_drop, out_of_stock;
  logic [2:0] stock;

  coffee_dispense_ctrl #(
    .CUP_CYC(CUP), .BREW_CYC(BREW), .POUR_CYC(POUR), .COIN_GAP(GAP), .STOCK(STK)
  ) dut (
    .clk(clk), .rst(rst), .coffee(coffee), .balance(balance),
    .cup_drop(cup_drop), .brew_on(brew_on), .pour_on(pour_on),
    .change_coin(change_coin), .busy(busy), .done(done), .reject(reject),
    .req_drop(req_drop), .stock(stock), .out_of_stock(out_of_stock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int coins;
    int lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_done = 0;
  int   n_drop = 0;
  int   n_rej  = 0;

  // per-dispense observations
  bit in_disp;
  int lat, ncup, nbrew, npour, ncoin, first_coin, last_coin;
  bit ovl, badgap;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input int bal);
    exp_t e;
    int   c;
    c       = CHG ? bal / 5 : 0;
    e.coins = c;
    e.lat   = CUP + BREW + POUR + 1 + (CHG ? ((c * GAP > 1) ? c * GAP : 1) : 0);
    return e;
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_disp = 1'b0;
        exp_q.delete();
      end else begin
        if (reject)   n_rej++;
        if (req_drop) n_drop++;
        if (cup_drop && !in_disp) begin
          in_disp = 1'b1;
          lat = 0; ncup = 0; nbrew = 0; npour = 0; ncoin = 0;
          first_coin = 0; last_coin = 0; ovl = 1'b0; badgap = 1'b0;
        end
        if (in_disp) begin
          lat++;
          ncup  += int'(cup_drop);
          nbrew += int'(brew_on);
          npour += int'(pour_on);
          if (int'(cup_drop) + int'(brew_on) + int'(pour_on) + int'(change_coin) > 1) ovl = 1'b1;
          if (change_coin) begin
            if (ncoin == 0) first_coin = lat;
            else if (lat - last_coin != GAP) badgap = 1'b1;
            last_coin = lat;
            ncoin++;
          end
          if (done) begin
            n_done++;
            in_disp = 1'b0;
            if (exp_q.size() == 0) begin
              chk("done_without_request", exp_q.size(), 1);
            end else begin
              e = exp_q.pop_front();
              chk("cup_cycles", ncup, CUP);
              chk("brew_cycles", nbrew, BREW);
              chk("pour_cycles", npour, POUR);
              chk("coin_count", ncoin, e.coins);
              chk("done_latency", lat, e.lat);
              chk("actuator_overlap", int'(ovl), 0);
              chk("coin_spacing", int'(badgap), 0);
              if (e.coins > 0) chk("first_coin_cycle", first_coin, CUP + BREW + POUR + 1);
            end
          end
        end
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called right after a negedge; returns at the negedge after the request edge.
  task automatic vend(input int bal, input bit accept);
    coffee  = 2'b01;
    balance = 6'(bal);
    if (accept) exp_q.push_back(mk(bal));
    @(negedge clk);
    coffee = 2'b00;
  endtask

  task automatic wait_done(input int max);
    int k = 0;
    while (done !== 1'b1 && k < max) begin
      @(negedge clk);
      k++;
    end
    if (done !== 1'b1) chk("done_timeout", int'(done), 1);
  endtask

  task automatic wait_brew(input int max);
    int k = 0;
    while (brew_on !== 1'b1 && k < max) begin
      @(negedge clk);
      k++;
    end
    if (brew_on !== 1'b1) chk("brew_timeout", int'(brew_on), 1);
  endtask

  task automatic check_quiet(input string phase);
    chk({phase, "_cup_drop"}, int'(cup_drop), 0);
    chk({phase, "_brew_on"}, int'(brew_on), 0);
    chk({phase, "_pour_on"}, int'(pour_on), 0);
    chk({phase, "_change_coin"}, int'(change_coin), 0);
    chk({phase, "_busy"}, int'(busy), 0);
    chk({phase, "_done"}, int'(done), 0);
    chk({phase, "_stock"}, int'(stock), STK);
  endtask

  initial begin
    int d0, dr0, rj0;
    rst     = 1'b1;
    coffee  = 2'b00;
    balance = 6'd0;
    fork
      monitor();
    join_none

    // Reset state
    tick(3);
    check_quiet("reset");
    chk("reset_reject", int'(reject), 0);
    chk("reset_req_drop", int'(req_drop), 0);
    chk("reset_out_of_stock", int'(out_of_stock), 0);
    rst = 1'b0;
    tick(1);

    // Basic dispense, no change
    vend(0, 1'b1);
    chk("accept_cup_drop", int'(cup_drop), 1);
    chk("accept_busy", int'(busy), 1);
    chk("accept_stock", int'(stock), STK - 1);
    wait_done(100);
    tick(2);

    // Change amounts, including a dropped remainder
    vend(15, 1'b1);
    wait_done(100);
    tick(1);
    vend(17, 1'b1);
    wait_done(100);
    tick(2);

    // Held vend level gives one dispense only
    d0  = n_done;
    dr0 = n_drop;
    coffee  = 2'b01;
    balance = 6'd5;
    exp_q.push_back(mk(5));
    tick(40);
    coffee = 2'b00;
    tick(5);
    chk("held_single_dispense", n_done - d0, 1);
    chk("held_no_drop", n_drop - dr0, 0);
    chk("held_idle_after", int'(busy), 0);

    // Queue: one request kept with its own balance, the next dropped
    dr0 = n_drop;
    vend(10, 1'b1);
    wait_brew(50);
    vend(20, 1'b1);
    tick(3);
    vend(25, 1'b0);
    wait_done(200);
    @(negedge clk);
    chk("queued_back_to_back", int'(cup_drop), 1);
    wait_done(200);
    tick(2);
    chk("queue_drop_count", n_drop - dr0, 1);
    chk("queue_stock", int'(stock), 1);

    // Last cup, then refusal on empty stock
    vend(0, 1'b1);
    wait_done(100);
    tick(2);
    chk("empty_stock", int'(stock), 0);
    chk("empty_out_of_stock", int'(out_of_stock), 1);
    rj0 = n_rej;
    vend(0, 1'b0);
    chk("empty_reject", int'(reject), 1);
    chk("empty_not_busy", int'(busy), 0);
    tick(1);
    chk("empty_reject_count", n_rej - rj0, 1);
    chk("empty_stock_held", int'(stock), 0);

    // Reset restores stock
    rst = 1'b1;
    @(negedge clk);
    check_quiet("reload");
    @(negedge clk);
    rst = 1'b0;
    tick(1);

    // Reset in the middle of brewing
    vend(10, 1'b1);
    chk("mid_accept_stock", int'(stock), STK - 1);
    wait_brew(50);
    tick(3);
    rst = 1'b1;
    @(negedge clk);
    check_quiet("midbrew");
    @(negedge clk);
    rst = 1'b0;
    tick(1);
    vend(15, 1'b1);
    wait_done(100);
    tick(2);
    chk("post_reset_stock", int'(stock), STK - 1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
